// File: rtl/fft_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : fft_pipeline_controller
// Purpose  : Sequencing for an S-stage radix-2 SDF FFT: butterfly selects,
//            twiddle addresses, output valid/framing and bit-reversed index.
// Revision : 1.0
// ============================================================================
module fft_pipeline_controller #(
    parameter int NFFT      = 64,
    parameter int STAGE_LAT = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start_conv,
    input  logic                                     stop_conv,
    output logic                                     in_accept,
    output logic [$clog2(NFFT)-1:0]                  sel,
    output logic [$clog2(NFFT)*($clog2(NFFT)-1)-1:0] tw_addr,
    output logic                                     out_valid,
    output logic                                     out_frame_start,
    output logic [$clog2(NFFT)-1:0]                  out_index,
    output logic                                     busy
);

    localparam int c_S   = $clog2(NFFT);
    localparam int c_TW  = c_S - 1;
    localparam int c_LAT = (NFFT - 1) + c_S * STAGE_LAT;
    localparam int c_CW  = $clog2(c_LAT + 1);

    function automatic int stage_off(input int s);
        int acc;
        acc = 0;
        for (int j = 1; j < s; j++) acc += (NFFT >> j) + STAGE_LAT;
        return acc;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [c_S-1:0]    in_cnt_q, in_cnt_d;
    logic [c_S-1:0]    out_cnt_q, out_cnt_d;
    logic [c_S-1:0]    sel_dly_q;
    logic [15:0]       frames_in_q, frames_in_d;
    logic [15:0]       frames_out_q, frames_out_d;
    logic              stop_pend_q, stop_pend_d;
    logic              out_on_q, out_on_d;
    logic [c_CW-1:0]   cyc_q, cyc_d;

    logic [c_S-1:0]      w_sel;
    logic [c_S*c_TW-1:0] w_tw;
    logic [c_S-1:0]      w_rev;
    logic                w_busy, w_acc, w_in_wrap, w_out_wrap, w_last_in, w_last_out;

    assign w_busy     = (state_q != IDLE);
    assign w_acc      = (state_q == FILL) || (state_q == RUN);
    assign w_in_wrap  = (in_cnt_q == c_S'(NFFT - 1));
    assign w_out_wrap = out_on_q && (out_cnt_q == c_S'(NFFT - 1));
    assign w_last_in  = w_acc && stop_pend_q && w_in_wrap;
    // Frame counters only ever differ by in-flight frames; equality after
    // this output's increment means nothing is left in the pipe.
    assign w_last_out = w_out_wrap && (16'(frames_out_q + 16'd1) == frames_in_q);

    always_comb begin
        state_d      = state_q;
        stop_pend_d  = stop_pend_q;
        in_cnt_d     = in_cnt_q;
        cyc_d        = cyc_q;
        out_on_d     = out_on_q;
        out_cnt_d    = out_cnt_q;
        frames_in_d  = frames_in_q;
        frames_out_d = frames_out_q;

        if (w_busy) begin
            in_cnt_d = in_cnt_q + 1'b1;
            if (cyc_q != c_CW'(c_LAT)) cyc_d = cyc_q + 1'b1;
            if (cyc_q == c_CW'(c_LAT - 1)) out_on_d = 1'b1;
        end
        if (w_acc && stop_conv) stop_pend_d = 1'b1;
        if (w_acc && w_in_wrap) frames_in_d = frames_in_q + 16'd1;
        if (out_on_q) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (w_out_wrap) frames_out_d = frames_out_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start_conv) begin
                    state_d     = FILL;
                    stop_pend_d = stop_conv;
                end
            end
            FILL: begin
                if (w_last_in) state_d = DRAIN;
                else if (cyc_q == c_CW'(c_LAT - 1)) state_d = RUN;
            end
            RUN: begin
                if (w_last_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (w_last_out) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                    in_cnt_d    = '0;
                    cyc_d       = '0;
                    out_on_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stop_pend_q  <= 1'b0;
            in_cnt_q     <= '0;
            cyc_q        <= '0;
            out_on_q     <= 1'b0;
            out_cnt_q    <= '0;
            frames_in_q  <= '0;
            frames_out_q <= '0;
            sel_dly_q    <= '0;
        end else begin
            state_q      <= state_d;
            stop_pend_q  <= stop_pend_d;
            in_cnt_q     <= in_cnt_d;
            cyc_q        <= cyc_d;
            out_on_q     <= out_on_d;
            out_cnt_q    <= out_cnt_d;
            frames_in_q  <= frames_in_d;
            frames_out_q <= frames_out_d;
            sel_dly_q    <= w_sel;
        end
    end

    // A stage stays quiet until the first sample has travelled OFF_s cycles.
    for (genvar gs = 1; gs <= c_S; gs++) begin : g_stage
        localparam int c_OFF = stage_off(gs);
        localparam int c_D   = NFFT >> gs;
        logic [c_S-1:0] w_c;
        logic           w_en;

        assign w_c           = in_cnt_q - c_S'(c_OFF % NFFT);
        assign w_en          = w_busy && (cyc_q >= c_CW'(c_OFF));
        assign w_sel[gs-1]   = w_en && w_c[c_S-gs];

        if (gs < c_S) begin : g_tw
            logic [c_S-1:0] w_m;
            assign w_m = (w_c - 1'b1) & c_S'(c_D - 1);
            assign w_tw[(gs-1)*c_TW +: c_TW] =
                (w_en && !sel_dly_q[gs-1]) ? c_TW'(w_m << (gs - 1)) : '0;
        end else begin : g_tw_tie
            assign w_tw[(gs-1)*c_TW +: c_TW] = '0;
        end
    end

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < c_S; i++) w_rev[i] = out_cnt_q[c_S-1-i];
    end

    assign in_accept       = !rst && w_acc;
    assign busy            = !rst && w_busy;
    assign out_valid       = !rst && out_on_q;
    assign out_frame_start = out_valid && (out_cnt_q == '0);
    assign out_index       = out_valid ? w_rev : '0;
    assign sel             = rst ? '0 : w_sel;
    assign tw_addr         = rst ? '0 : w_tw;

endmodule
`default_nettype wire

// File: doc/fft_pipeline_controller.md
FFT_PIPELINE_CONTROLLER -- requirements
Module: fft_pipeline_controller

Interface
REQ-001 Parameter NFFT, default 64: FFT size; power of two, 8 to 1024.
REQ-002 Parameter STAGE_LAT, default 2: register cycles per stage in addition to that stage's buffer depth.
REQ-003 Derived constants: S = log2(NFFT); D_s = NFFT >> s for stage s = 1..S; OFF_1 = 0; OFF_s = sum over j < s of (D_j + STAGE_LAT); LAT = (NFFT-1) + S*STAGE_LAT.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start_conv  in  1  one-cycle start pulse; honoured only in IDLE.
REQ-007 stop_conv  in  1  one-cycle request to stop input at the end of the current input frame.
REQ-008 in_accept  out  1  high when the sample on the stage-1 input is consumed this cycle.
REQ-009 sel  out  S  sel[s-1] is the butterfly/MUX1 select for stage s.
REQ-010 tw_addr  out  S*(S-1)  field s-1 is the (S-1)-bit twiddle ROM address for stage s; the stage-S field is tied to 0.
REQ-011 out_valid  out  1  stage-S output sample is valid.
REQ-012 out_frame_start  out  1  high with the first valid output sample of each frame.
REQ-013 out_index  out  S  natural-order bin index of the current output sample.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, FILL, RUN, DRAIN.
REQ-016 IDLE->FILL when start_conv=1; on the next cycle in_cnt=0 and in_accept=1.
REQ-017 FILL->RUN after LAT cycles of FILL, i.e. when the first out_valid asserts.
REQ-018 FILL/RUN->DRAIN when stop_pending=1 and in_cnt=NFFT-1; that sample is the last one accepted.
REQ-019 DRAIN->IDLE on the cycle after the last output sample of the last accepted frame (out_cnt=NFFT-1 with frames_out=frames_in).
REQ-020 stop_pending is set by stop_conv in FILL or RUN and cleared on entry to IDLE.
REQ-021 start_conv outside IDLE is ignored.
REQ-022 start_conv and stop_conv together in IDLE start the block with stop_pending=1, so exactly one frame is processed.
REQ-023 in_cnt (S bits) increments every cycle in FILL, RUN and DRAIN and wraps NFFT-1->0; in_accept=1 only in FILL and RUN.
REQ-024 Stage counter c_s = (in_cnt - OFF_s) mod NFFT, computed combinationally from in_cnt; no per-stage counters.
REQ-025 sel[s-1] = bit (S-s) of c_s when busy, else 0: stage 1 is low for 32 samples and high for 32; stage S alternates every cycle.
REQ-026 Stage s < S: tw_addr field = ((c_s - D_s - 1) mod D_s) << (s-1) during the one-cycle-delayed difference branch (delayed sel low); otherwise 0.
REQ-027 out_valid asserts exactly LAT cycles after an accepted sample and stays high for every accepted sample; it is otherwise 0.
REQ-028 out_cnt counts valid outputs modulo NFFT; out_index = bit-reverse(out_cnt); out_frame_start = out_valid and out_cnt=0.
REQ-029 frames_in and frames_out are 16-bit counters that increment at each frame end and wrap; only their equality is used.
REQ-030 A frame cut short by reset is discarded; no partial-frame output is produced.

Reset
REQ-031 rst=1 at a clock edge forces IDLE from any state and clears in_cnt, out_cnt, frames_in, frames_out and stop_pending.
REQ-032 While rst=1 and on the cycle after reset, every output is 0.
REQ-033 rst has priority over start_conv in the same cycle.

Verification
REQ-034 NFFT=64, STAGE_LAT=2, pulse start_conv -> in_accept rises the next cycle; first out_valid follows 75 cycles after the first accept, together with out_frame_start=1 and out_index=0; the second valid sample has out_index=32.
REQ-035 Same run -> sel[0]=0 for in_cnt 0..31 and 1 for 32..63; sel[1] is first high at in_cnt=50 (OFF_2=34, c_2=16); sel[5] toggles every cycle from in_cnt=72.
REQ-036 Continuous run of 3 frames, stop_conv at in_cnt=10 of frame 3 -> in_accept falls after in_cnt=63 of frame 3; exactly 192 out_valid cycles; busy falls on the cycle after the final output (out_index=63).
REQ-037 start_conv and stop_conv in the same IDLE cycle -> exactly 64 accepted and 64 valid output samples, then IDLE.
REQ-038 rst asserted 40 cycles into FILL -> next cycle state is IDLE and all outputs are 0; a new start_conv then reproduces the REQ-034 timing exactly.
REQ-039 start_conv pulsed during RUN -> no change to in_cnt, sel or output timing.
